// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive buffer:
//   - default FIFO geometry (DEPTH_DEF / ADDR_W_DEF)
//   - default character-timeout length (TO_CYCLES_DEF)
//   - TRIG_LVL encodings and the threshold lookup helper
//   - one-hot state encoding of the optional character-timeout FSM
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEPTH_DEF     = 16;
    localparam int ADDR_W_DEF    = 4;
    // 4 characters x 10 bits x 16x oversampling
    localparam int TO_CYCLES_DEF = 640;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } trig_lvl_e;

    typedef enum logic [2:0] {
        TO_IDLE  = 3'b001,
        TO_COUNT = 3'b010,
        TO_FIRED = 3'b100
    } to_state_e;

    // Occupancy at which RX_IRQ asserts for a given TRIG_LVL setting.
    function automatic int trig_threshold(input logic [1:0] sel, input int depth);
        case (sel)
            TRIG_ONE:       return 1;
            TRIG_QUARTER:   return depth / 4;
            TRIG_HALF:      return depth / 2;
            default:        return depth - 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x 8 dual-port register array: synchronous write, registered read.
// The array itself is not reset; only the read data register is.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write byte
//   rd_en    in   read strobe; rd_data loads mem[rd_addr] on the edge
//   rd_addr  in   read index
//   rd_data  out  registered read byte, holds when rd_en is low
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write and a read of the same index on one edge return the old byte;
    // this is what makes push+pop on a full FIFO safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer downstream of the UART receiver. Captures RX_VALID/RX_DATA
// strobes into a circular FIFO, serves the host read port with one cycle of
// latency, and reports level, threshold IRQ, sticky overrun and (optionally)
// a character timeout.
// Build option: define UART_RX_TIMEOUT_EN to include the timeout FSM;
// otherwise TO_IRQ is tied low.
// Ports:
//   BCLK      in   clock
//   rst_n     in   asynchronous active-low reset
//   RX_VALID  in   one-cycle byte strobe from the receiver
//   RX_DATA   in   received byte
//   RD_EN     in   host pop request
//   RD_DATA   out  popped byte (registered)
//   RD_VALID  out  RD_DATA valid pulse, one cycle after an accepted pop
//   EMPTY     out  LEVEL == 0 (registered)
//   FULL      out  LEVEL == DEPTH (registered)
//   LEVEL     out  occupancy 0..DEPTH (registered)
//   TRIG_LVL  in   RX_IRQ threshold select
//   RX_IRQ    out  LEVEL >= threshold (registered)
//   OVERRUN   out  sticky: byte dropped because FIFO was full
//   OVR_CLR   in   clears OVERRUN (a simultaneous new overrun wins)
//   TO_IRQ    out  character timeout interrupt
// Handshake: a byte is accepted whenever RX_VALID is high and the FIFO is not
// full, or is full but a pop happens on the same edge; a pop is accepted when
// RD_EN is high and EMPTY is low, and its byte appears with RD_VALID one
// cycle later. There is no back-pressure toward the receiver.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic              BCLK,
    input  logic              rst_n,
    input  logic              RX_VALID,
    input  logic [7:0]        RX_DATA,
    input  logic              RD_EN,
    output logic [7:0]        RD_DATA,
    output logic              RD_VALID,
    output logic              EMPTY,
    output logic              FULL,
    output logic [ADDR_W:0]   LEVEL,
    input  logic [1:0]        TRIG_LVL,
    output logic              RX_IRQ,
    output logic              OVERRUN,
    input  logic              OVR_CLR,
    output logic              TO_IRQ
);

    if (DEPTH < 4 || DEPTH != (1 << ADDR_W) || TO_CYCLES < 1) begin : g_cfg_err
        $error("uart_rx_fifo: DEPTH must be 2**ADDR_W and >= 4, TO_CYCLES >= 1");
    end

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_next;
    logic [ADDR_W:0] rd_next;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] irq_thr;
    logic            push;
    logic            pop;

    // Flags are registered, so push/pop decisions use last edge's state.
    // A full FIFO still accepts a byte if a pop frees a slot on the same edge.
    assign pop     = RD_EN && !EMPTY;
    assign push    = RX_VALID && (!FULL || pop);
    assign wr_next = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_next = rd_ptr + {{ADDR_W{1'b0}}, pop};
    // Extra pointer MSB makes the difference span 0..DEPTH unambiguously.
    assign level_next = wr_next - rd_next;
    assign irq_thr    = (ADDR_W + 1)'(trig_threshold(TRIG_LVL, DEPTH));

    always_ff @(posedge BCLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LEVEL    <= '0;
            EMPTY    <= 1'b1;
            FULL     <= 1'b0;
            RX_IRQ   <= 1'b0;
            RD_VALID <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            LEVEL    <= level_next;
            EMPTY    <= (level_next == '0);
            FULL     <= (level_next == (ADDR_W + 1)'(DEPTH));
            RX_IRQ   <= (level_next >= irq_thr);
            RD_VALID <= pop;
            if (RX_VALID && !push) begin
                OVERRUN <= 1'b1;
            end else if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (BCLK),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (RX_DATA),
        .rd_en   (pop),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (RD_DATA)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    // to_state is the observable FSM state for checkers.
    to_state_e        to_state;
    to_state_e        to_state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_nxt;

    always_ff @(posedge BCLK or negedge rst_n) begin
        if (!rst_n) begin
            to_state <= TO_IDLE;
            to_cnt   <= '0;
        end else begin
            to_state <= to_state_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

    always_comb begin
        to_state_nxt = to_state;
        to_cnt_nxt   = to_cnt;
        case (to_state)
            TO_IDLE: begin
                if (LEVEL != '0) begin
                    to_state_nxt = TO_COUNT;
                    to_cnt_nxt   = '0;
                end
            end
            TO_COUNT: begin
                if (LEVEL == '0) begin
                    to_state_nxt = TO_IDLE;
                    to_cnt_nxt   = '0;
                end else if (push || pop) begin
                    to_cnt_nxt = '0;
                end else if (to_cnt == CNT_W'(TO_CYCLES - 1)) begin
                    to_state_nxt = TO_FIRED;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            TO_FIRED: begin
                if (LEVEL == '0) begin
                    to_state_nxt = TO_IDLE;
                    to_cnt_nxt   = '0;
                end else if (push || pop) begin
                    to_state_nxt = TO_COUNT;
                    to_cnt_nxt   = '0;
                end
            end
            default: begin
                to_state_nxt = TO_IDLE;
                to_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        TO_IRQ = (to_state == TO_FIRED);
    end
`else
    assign TO_IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo: a directed vector table, hand-written
// corner sequences (full/overrun, push+pop on full/empty, IRQ threshold,
// timeout, asynchronous reset) and randomized traffic checked against a
// queue-based reference model.
// Honours UART_RX_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              bclk;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   level;
    logic [1:0]        trig_lvl;
    logic              rx_irq;
    logic              overrun;
    logic              ovr_clr;
    logic              to_irq;

    uart_rx_fifo dut (
        .BCLK     (bclk),
        .rst_n    (rst_n),
        .RX_VALID (rx_valid),
        .RX_DATA  (rx_data),
        .RD_EN    (rd_en),
        .RD_DATA  (rd_data),
        .RD_VALID (rd_valid),
        .EMPTY    (empty),
        .FULL     (full),
        .LEVEL    (level),
        .TRIG_LVL (trig_lvl),
        .RX_IRQ   (rx_irq),
        .OVERRUN  (overrun),
        .OVR_CLR  (ovr_clr),
        .TO_IRQ   (to_irq)
    );

    // ---------------- clock / watchdog ----------------
    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_ovr;
    logic       m_irq;

    function automatic int thr_of(input logic [1:0] t);
        case (t)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rd_data  = 8'h00;
        m_rd_valid = 1'b0;
        m_ovr      = 1'b0;
        m_irq      = 1'b0;
    endtask

    // One clock of FIFO behaviour expressed as queue operations.
    task automatic model_update(input logic rv, input logic [7:0] d,
                                input logic rd, input logic clr);
        int   sz;
        logic pop_ok;
        logic push_ok;
        sz      = exp_q.size();
        pop_ok  = rd && (sz > 0);
        push_ok = rv && ((sz < DEPTH) || pop_ok);
        if (pop_ok) m_rd_data = exp_q.pop_front();
        m_rd_valid = pop_ok;
        if (push_ok) exp_q.push_back(d);
        if (rv && !push_ok) m_ovr = 1'b1;
        else if (clr)       m_ovr = 1'b0;
        m_irq = (exp_q.size() >= thr_of(trig_lvl));
    endtask

    task automatic check_model();
        chk("rd_valid", rd_valid, m_rd_valid);
        chk("rd_data",  rd_data,  m_rd_data);
        chk("level",    level,    exp_q.size());
        chk("empty",    empty,    exp_q.size() == 0);
        chk("full",     full,     exp_q.size() == DEPTH);
        chk("rx_irq",   rx_irq,   m_irq);
        chk("overrun",  overrun,  m_ovr);
`ifndef UART_RX_TIMEOUT_EN
        chk("to_irq_tied", to_irq, 1'b0);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic rv, input logic [7:0] d, input logic rd, input logic clr);
        rx_valid = rv;
        rx_data  = d;
        rd_en    = rd;
        ovr_clr  = clr;
        @(posedge bclk);
        #1;
        model_update(rv, d, rd, clr);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_data"},  rd_data,  8'h00);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_empty"},    empty,    1'b1);
        chk({tag, "_full"},     full,     1'b0);
        chk({tag, "_level"},    level,    0);
        chk({tag, "_rx_irq"},   rx_irq,   1'b0);
        chk({tag, "_overrun"},  overrun,  1'b0);
        chk({tag, "_to_irq"},   to_irq,   1'b0);
    endtask

    task automatic do_reset(input string tag);
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_reset_values(tag);
        repeat (2) @(posedge bclk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic       rd;
        logic       rdv_e;
        logic [7:0] rdd_e;
        logic [4:0] lvl_e;
        logic       empty_e;
        logic       irq_e;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n_idle;
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
        trig_lvl = 2'b00;
        model_reset();
        #1;
        do_reset("rst");

        // Push A5,3C,0F, pop three, pop on empty, push+pop on empty, pop.
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h0F, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd2, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 5'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 5'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h0F, 5'd1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 5'd0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].rv, tbl[i].d, tbl[i].rd, 1'b0);
            chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].rdv_e);
            chk($sformatf("tbl%0d_rd_data", i),  rd_data,  tbl[i].rdd_e);
            chk($sformatf("tbl%0d_level", i),    level,    tbl[i].lvl_e);
            chk($sformatf("tbl%0d_empty", i),    empty,    tbl[i].empty_e);
            chk($sformatf("tbl%0d_rx_irq", i),   rx_irq,   tbl[i].irq_e);
        end

        // Fill to full, overrun, push+pop on full, set-vs-clear priority.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check_model();
        end
        chk("full_after_16", full, 1'b1);
        chk("level_16", level, 16);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check_model();
        chk("overrun_set", overrun, 1'b1);
        chk("level_after_drop", level, 16);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check_model();
        chk("full_pushpop_rd_data", rd_data, 8'h00);
        chk("full_pushpop_rd_valid", rd_valid, 1'b1);
        chk("full_pushpop_level", level, 16);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        check_model();
        chk("overrun_set_wins", overrun, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check_model();
        end
        chk("last_byte_77", rd_data, 8'h77);
        chk("drained_empty", empty, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_model();
        chk("overrun_cleared", overrun, 1'b0);

        // IRQ threshold at DEPTH/2.
        trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            check_model();
        end
        chk("irq_below_half", rx_irq, 1'b0);
        cyc(1'b1, 8'h47, 1'b0, 1'b0);
        check_model();
        chk("irq_at_half", rx_irq, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_model();
        chk("irq_after_pop", rx_irq, 1'b0);
        trig_lvl = 2'b01;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_model();
        chk("irq_trig_change", rx_irq, 1'b1);
        while (exp_q.size() > 0) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check_model();
        end

        // Randomized traffic, three push/pop biases to reach empty and full.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) trig_lvl = 2'($urandom_range(0, 3));
                cyc(($urandom_range(0, 99) < (70 - 20 * ph)),
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < (30 + 20 * ph)),
                    ($urandom_range(0, 19) == 0));
                check_model();
            end
        end
        while (exp_q.size() > 0) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check_model();
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_model();

        // Character timeout: one byte then idle.
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        check_model();
`ifdef UART_RX_TIMEOUT_EN
        n_idle = 0;
        while (!to_irq && n_idle < 700) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            n_idle++;
            if (n_idle == 600) chk("to_not_early", to_irq, 1'b0);
        end
        chk("to_irq_fired", to_irq, 1'b1);
        chk("to_fire_window", (n_idle >= 640 && n_idle <= 642), 1'b1);
        check_model();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_model();
        chk("to_irq_cleared_by_pop", to_irq, 1'b0);
`else
        n_idle = 0;
        repeat (700) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            n_idle++;
        end
        check_model();
        chk("idle_cycles_run", n_idle, 700);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_model();
`endif

        // Asynchronous reset in the middle of activity.
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        check_model();
        do_reset("midrst");
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_model();
        chk("midrst_nothing_left", rd_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
